// File: rtl/uart_rx_fifo.sv
// ----------------------------------------------------------------------------
// uart_rx_fifo
//   Receive-side byte buffer placed directly after the UART receiver. Every
//   rx_done pulse (wr_en) captures one received byte; the consumer drains the
//   queue through a first-word-fall-through valid/ready port. Bytes that
//   arrive while the queue is full and nothing is leaving are dropped, and a
//   sticky overflow flag records the loss.
//
// Parameters
//   WIDTH      data width (matches the UART received_byte)
//   DEPTH      number of entries, power of 2, >= 2
//   AF_THRESH  almost_full asserts when count >= AF_THRESH (1..DEPTH)
//
// Ports
//   clk            in   system clock, all state on posedge
//   rst            in   synchronous active-high reset, dominates all inputs
//   wr_data        in   byte from the receiver
//   wr_en          in   one-cycle pulse per received byte
//   rd_data        out  head-of-queue byte, valid while rd_valid=1
//   rd_valid       out  queue non-empty
//   rd_ready       in   consumer takes rd_data this cycle
//   count          out  occupancy 0..DEPTH
//   full           out  count == DEPTH
//   almost_full    out  count >= AF_THRESH
//   overflow       out  sticky, a write was dropped
//   overflow_clr   in   clears overflow (a same-cycle drop wins)
// ----------------------------------------------------------------------------
module uart_rx_fifo #(
   parameter int WIDTH     = 8,
   parameter int DEPTH     = 16,
   parameter int AF_THRESH = 12
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [WIDTH-1:0]           wr_data,
   input  logic                       wr_en,
   output logic [WIDTH-1:0]           rd_data,
   output logic                       rd_valid,
   input  logic                       rd_ready,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       full,
   output logic                       almost_full,
   output logic                       overflow,
   input  logic                       overflow_clr
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   // Storage is intentionally not reset; rd_data is don't-care while empty.
   logic [WIDTH-1:0] mem_q [DEPTH];

   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q,  count_d;
   logic          ovf_q,    ovf_d;

   logic push, pop, drop;

   // Status flags come straight from the registered count, so they reflect
   // the state after the most recent edge.
   assign rd_valid    = (count_q != '0);
   assign full        = (count_q == CW'(DEPTH));
   assign almost_full = (count_q >= CW'(AF_THRESH));
   assign count       = count_q;
   assign overflow    = ovf_q;

   // First-word-fall-through: the head entry is always on the output.
   assign rd_data     = mem_q[rd_ptr_q];

   // A pop in the same cycle frees a slot, so a write at full still fits.
   assign pop  = rd_valid & rd_ready;
   assign push = wr_en & (~full | pop);
   assign drop = wr_en & ~push;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      ovf_d    = ovf_q;

      // DEPTH is a power of two, so the natural pointer rollover is the wrap.
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);

      unique case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase

      // Set has priority over clear.
      if (drop)              ovf_d = 1'b1;
      else if (overflow_clr) ovf_d = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         ovf_q    <= ovf_d;
      end
   end

   // Write port kept out of the reset branch so the array maps to plain RAM.
   always_ff @(posedge clk) begin
      if (!rst && push) mem_q[wr_ptr_q] <= wr_data;
   end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// ----------------------------------------------------------------------------
// tb_uart_rx_fifo
//   Directed scenarios followed by randomized traffic. A queue-based model
//   tracks the expected contents and the overflow flag; every cycle the DUT
//   outputs are compared against it at the falling edge.
// ----------------------------------------------------------------------------
module tb_uart_rx_fifo;

   localparam int WIDTH = 8;
   localparam int DEPTH = 16;
   localparam int AFT   = 12;
   localparam int CW    = $clog2(DEPTH+1);

   logic             clk = 1'b0;
   logic             rst;
   logic [WIDTH-1:0] wr_data;
   logic             wr_en;
   logic [WIDTH-1:0] rd_data;
   logic             rd_valid;
   logic             rd_ready;
   logic [CW-1:0]    count;
   logic             full;
   logic             almost_full;
   logic             overflow;
   logic             overflow_clr;

   int total = 0;
   int bad   = 0;

   logic [WIDTH-1:0] mq[$];
   logic             movf;

   always #5 clk = ~clk;

   uart_rx_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AF_THRESH(AFT)) dut (
      .clk          (clk),
      .rst          (rst),
      .wr_data      (wr_data),
      .wr_en        (wr_en),
      .rd_data      (rd_data),
      .rd_valid     (rd_valid),
      .rd_ready     (rd_ready),
      .count        (count),
      .full         (full),
      .almost_full  (almost_full),
      .overflow     (overflow),
      .overflow_clr (overflow_clr)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   // Compare all outputs against the model's view of the queue.
   task automatic check_model();
      chk("rd_valid", 32'(rd_valid), 32'(mq.size() > 0));
      chk("count", 32'(count), 32'(mq.size()));
      chk("full", 32'(full), 32'(mq.size() == DEPTH));
      chk("almost_full", 32'(almost_full), 32'(mq.size() >= AFT));
      chk("overflow", 32'(overflow), 32'(movf));
      if (mq.size() > 0) chk("rd_data", 32'(rd_data), 32'(mq[0]));
   endtask

   // Apply the currently driven inputs for one edge, update the model, check.
   task automatic tick();
      bit pop, push, drop;
      pop  = (mq.size() > 0) && rd_ready;
      push = wr_en && ((mq.size() < DEPTH) || pop);
      drop = wr_en && !push;
      @(posedge clk);
      if (rst) begin
         mq.delete();
         movf = 1'b0;
      end else begin
         if (pop)  void'(mq.pop_front());
         if (push) mq.push_back(wr_data);
         if (drop)              movf = 1'b1;
         else if (overflow_clr) movf = 1'b0;
      end
      @(negedge clk);
      check_model();
   endtask

   task automatic drv(input bit we, input logic [WIDTH-1:0] d, input bit rr, input bit clr);
      rst          = 1'b0;
      wr_en        = we;
      wr_data      = d;
      rd_ready     = rr;
      overflow_clr = clr;
      tick();
   endtask

   task automatic do_reset();
      rst = 1'b1; wr_en = 1'b1; wr_data = 8'hEE; rd_ready = 1'b0; overflow_clr = 1'b0;
      tick();
   endtask

   task automatic fill(input logic [WIDTH-1:0] base);
      for (int i = 0; i < DEPTH; i++) drv(1'b1, base + WIDTH'(i), 1'b0, 1'b0);
   endtask

   task automatic drain();
      for (int i = 0; i < DEPTH + 2; i++) drv(1'b0, 8'h00, 1'b1, 1'b0);
   endtask

   initial begin
      movf = 1'b0;
      do_reset();
      do_reset();
      drv(1'b0, 8'h00, 1'b0, 1'b0);
      chk("rst_valid", 32'(rd_valid), 32'd0);
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_full", 32'(full), 32'd0);
      chk("rst_af", 32'(almost_full), 32'd0);
      chk("rst_ovf", 32'(overflow), 32'd0);

      // Two bytes, consumer waits one cycle, then drains back to back.
      drv(1'b1, 8'h96, 1'b0, 1'b0);
      chk("first_latency", 32'(rd_data), 32'h96);
      drv(1'b1, 8'h3C, 1'b0, 1'b0);
      drv(1'b0, 8'h00, 1'b0, 1'b0);
      chk("stall_hold", 32'(rd_data), 32'h96);
      chk("cnt2", 32'(count), 32'd2);
      drv(1'b0, 8'h00, 1'b1, 1'b0);
      chk("second", 32'(rd_data), 32'h3C);
      chk("cnt1", 32'(count), 32'd1);
      drv(1'b0, 8'h00, 1'b1, 1'b0);
      chk("cnt0", 32'(count), 32'd0);
      chk("empty", 32'(rd_valid), 32'd0);

      // Fill, watch thresholds, drop one byte, drain in order.
      for (int i = 0; i < DEPTH; i++) begin
         drv(1'b1, 8'(i), 1'b0, 1'b0);
         chk("af_thresh", 32'(almost_full), 32'((i + 1) >= AFT));
      end
      chk("full16", 32'(full), 32'd1);
      drv(1'b1, 8'hAA, 1'b0, 1'b0);
      chk("drop_ovf", 32'(overflow), 32'd1);
      chk("drop_cnt", 32'(count), 32'd16);
      for (int i = 0; i < DEPTH; i++) begin
         chk("drain_seq", 32'(rd_data), 32'(i));
         drv(1'b0, 8'h00, 1'b1, 1'b0);
      end
      chk("drained", 32'(rd_valid), 32'd0);
      drv(1'b0, 8'h00, 1'b0, 1'b1);
      chk("ovf_clr", 32'(overflow), 32'd0);

      // Write at full with a simultaneous pop is accepted.
      fill(8'h20);
      drv(1'b1, 8'h77, 1'b1, 1'b0);
      chk("fullrw_cnt", 32'(count), 32'd16);
      chk("fullrw_ovf", 32'(overflow), 32'd0);
      for (int i = 0; i < DEPTH - 1; i++) drv(1'b0, 8'h00, 1'b1, 1'b0);
      chk("fullrw_last", 32'(rd_data), 32'h77);
      drain();

      // Pointer wrap with overflow clear, then clear coincident with a drop.
      fill(8'h40);
      for (int i = 0; i < 5; i++) drv(1'b0, 8'h00, 1'b1, 1'b0);
      for (int i = 0; i < 5; i++) drv(1'b1, 8'h80 + 8'(i), 1'b0, 1'b0);
      drv(1'b1, 8'hBB, 1'b0, 1'b0);
      chk("wrap_ovf", 32'(overflow), 32'd1);
      drv(1'b0, 8'h00, 1'b0, 1'b1);
      chk("wrap_clr", 32'(overflow), 32'd0);
      drv(1'b1, 8'hCC, 1'b0, 1'b1);
      chk("clr_vs_drop", 32'(overflow), 32'd1);
      chk("wrap_head", 32'(rd_data), 32'h45);
      drain();
      drv(1'b0, 8'h00, 1'b0, 1'b1);

      // Reset discards queued bytes.
      for (int i = 0; i < 7; i++) drv(1'b1, 8'h10 + 8'(i), 1'b0, 1'b0);
      do_reset();
      chk("rstq_cnt", 32'(count), 32'd0);
      chk("rstq_valid", 32'(rd_valid), 32'd0);
      drv(1'b1, 8'h55, 1'b0, 1'b0);
      chk("post_rst", 32'(rd_data), 32'h55);
      drain();

      // Randomized traffic with varying producer/consumer pressure.
      for (int ph = 0; ph < 4; ph++) begin
         for (int n = 0; n < 600; n++) begin
            rst          = ($urandom_range(0, 299) == 0);
            wr_en        = ($urandom_range(0, 3) < (ph + 1));
            wr_data      = 8'($urandom);
            rd_ready     = ($urandom_range(0, 3) >= ph);
            overflow_clr = ($urandom_range(0, 19) == 0);
            tick();
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
